lfsr3_core: RTL and testbench

- 3-bit Galois-style linear feedback shift register with a synchronous parallel load.
- Board-level wrapper style: switches supply the seed, KEY[0] is the clock, KEY[1] is the synchronous active-high reset/load, and the LEDs show the register state.
- Built from three identical mux-plus-flip-flop bit cells.
- Feedback polynomial x^3 + x^2 + 1, giving a maximal period of 7.

---
 rtl/lfsr3_core_pkg.sv | 19 +
 rtl/lfsr3_core_if.sv | 12 +
 rtl/lfsr3_bitcell.sv | 16 +
 rtl/lfsr3_core.sv | 37 +++
 tb/tb_lfsr3_core.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/lfsr3_core_pkg.sv
// Shared constants and the next-state rule for the 3-bit Galois LFSR
// (polynomial x^3 + x^2 + 1, maximal period 7).
package lfsr3_core_pkg;

    localparam int LFSR_W = 3;

    typedef logic [LFSR_W-1:0] lfsr_t;

    // Per-bit shift input: bit0 <- Q2, bit1 <- Q0, bit2 <- Q1 ^ Q2.
    // Nonzero states cycle with period 7; 000 maps to itself.
    function automatic lfsr_t lfsr3_shift(input lfsr_t q);
        lfsr_t nxt;
        nxt[0] = q[2];
        nxt[1] = q[0];
        nxt[2] = q[1] ^ q[2];
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr3_core_if.sv
// Seed input and register-state output of the LFSR, grouped as one bus.
interface lfsr3_core_if;
    import lfsr3_core_pkg::*;

    lfsr_t SW;
    lfsr_t LEDR;

    // master: the board/switch side supplying the seed and watching the LEDs
    modport master (output SW, input LEDR);
    // slave: the LFSR core
    modport slave (input SW, output LEDR);
endinterface

// File: rtl/lfsr3_bitcell.sv
// One LFSR bit: 2:1 mux selecting the load value or the shift input,
// followed by a D flip-flop. Load is synchronous; there is no async path.
module lfsr3_bitcell (
    input  logic clk,
    input  logic load,
    input  logic r_in,
    input  logic q_in,
    output logic q
);

    // Register either the parallel-load bit or the shifted-in bit.
    always_ff @(posedge clk) begin
        q <= load ? r_in : q_in;
    end

endmodule

// File: rtl/lfsr3_core.sv
// 3-bit Galois LFSR with synchronous parallel load.
// KEY[0] is the clock, KEY[1] the active-high synchronous load/reset;
// while KEY[1] is high every edge reloads SW. LEDR comes straight from
// the flip-flops. Seeding 000 locks the register at 000; no auto-recovery.
module lfsr3_core
    import lfsr3_core_pkg::*;
(
    input  logic [1:0]         KEY,
    lfsr3_core_if.slave        bus
);

    logic  clk;
    logic  load;
    lfsr_t q;
    lfsr_t q_shift;

    assign clk  = KEY[0];
    assign load = KEY[1];

    // Feedback wiring for the shift path.
    always_comb begin
        q_shift = lfsr3_shift(q);
    end

    for (genvar i = 0; i < LFSR_W; i++) begin : g_bit
        lfsr3_bitcell u_cell (
            .clk  (clk),
            .load (load),
            .r_in (bus.SW[i]),
            .q_in (q_shift[i]),
            .q    (q[i])
        );
    end

    assign bus.LEDR = q;

endmodule

// File: tb/tb_lfsr3_core.sv
// Bench for lfsr3_core: table of load/shift vectors, hand-written
// multi-cycle corner cases, and a randomized run against a sequence model.
module tb_lfsr3_core;

    logic       clk;
    logic       rst;
    logic [1:0] KEY;

    lfsr3_core_if bus ();

    assign KEY = {rst, clk};

    lfsr3_core dut (
        .KEY (KEY),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the period-7 orbit written out as a list; the next state is
    // the following entry, and 000 is a fixed point.
    logic [2:0] orbit [7] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b111, 3'b011, 3'b110};
    logic [2:0] model;

    function automatic logic [2:0] ref_next(input logic [2:0] s);
        for (int k = 0; k < 7; k++)
            if (orbit[k] == s) return orbit[(k + 1) % 7];
        return 3'b000;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: LEDR=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, advance one rising edge, sample 1 later.
    task automatic step(input logic ld, input logic [2:0] sw);
        @(negedge clk);
        rst    = ld;
        bus.SW = sw;
        @(posedge clk);
        #1;
        model = ld ? sw : ref_next(model);
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] sw;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        bus.SW = 3'b000;
        model  = 3'b000;

        // load 001 and hold; free run full period; lock-up; reload mid-run; tracking
        vecs.push_back('{1'b1, 3'b001, 3'b001});
        vecs.push_back('{1'b1, 3'b001, 3'b001});
        vecs.push_back('{1'b0, 3'b111, 3'b010});
        vecs.push_back('{1'b0, 3'b000, 3'b100});
        vecs.push_back('{1'b0, 3'b101, 3'b101});
        vecs.push_back('{1'b0, 3'b000, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 3'b011});
        vecs.push_back('{1'b0, 3'b000, 3'b110});
        vecs.push_back('{1'b0, 3'b000, 3'b001});
        vecs.push_back('{1'b1, 3'b000, 3'b000});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 3'b101, 3'b000});
        vecs.push_back('{1'b1, 3'b001, 3'b001});
        vecs.push_back('{1'b0, 3'b000, 3'b010});
        vecs.push_back('{1'b0, 3'b000, 3'b100});
        vecs.push_back('{1'b0, 3'b000, 3'b101});
        vecs.push_back('{1'b1, 3'b110, 3'b110});
        vecs.push_back('{1'b0, 3'b110, 3'b001});
        vecs.push_back('{1'b1, 3'b011, 3'b011});
        vecs.push_back('{1'b1, 3'b100, 3'b100});
        vecs.push_back('{1'b1, 3'b011, 3'b011});

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].sw);
            check($sformatf("vec%0d", i), bus.LEDR, vecs[i].exp);
        end

        // Period: from seed 001 the register returns to 001 after exactly 7 shifts.
        begin
            int edges;
            step(1'b1, 3'b001);
            edges = 0;
            do begin
                step(1'b0, 3'b000);
                edges++;
            end while (bus.LEDR !== 3'b001 && edges < 20);
            n_cmp++;
            if (edges != 7) begin
                n_bad++;
                $display("FAIL period: edges=%0d expected=7", edges);
            end
        end

        // Synchronicity: wiggle KEY[1] and SW between edges; LEDR must hold.
        begin
            logic [2:0] held;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            model = ref_next(model);
            held  = bus.LEDR;
            check("sync_pre", held, model);
            #1; rst = 1'b1; bus.SW = 3'b110;
            #1; check("sync_mid1", bus.LEDR, held);
            #1; bus.SW = 3'b011; rst = 1'b0;
            #1; check("sync_mid2", bus.LEDR, held);
            #1; rst = 1'b1; bus.SW = 3'b101;
            #1; check("sync_mid3", bus.LEDR, held);
            @(posedge clk);
            #1;
            model = 3'b101;
            check("sync_edge", bus.LEDR, model);
        end

        // Randomized load/shift mix against the orbit model.
        for (int i = 0; i < 300; i++) begin
            logic       ld;
            logic [2:0] sw;
            ld = ($urandom_range(0, 3) == 0);
            sw = 3'($urandom_range(0, 7));
            if (model == 3'b000) ld = 1'b1;
            step(ld, sw);
            check($sformatf("rand%0d", i), bus.LEDR, model);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
